// File: rtl/mem_access_align_if.sv
// Request/response and data-bus signals of the memory access unit.
// The unit connects through the slave modport and its environment through the master modport.
interface mem_access_align_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, bus_ack, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, bus_ack, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/mem_access_align.sv
// Load/store alignment unit: lane-replicates stores, builds byte enables and
// extracts/extends load data, one access at a time with a bus timeout.
module mem_access_align #(
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    mem_access_align_if.slave io
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  count;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        sext_q;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;

    logic        misaligned;
    logic [3:0]  be;
    logic [31:0] wdata_lanes;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;

    assign io.req_ready = (state == IDLE);
    assign io.rsp_valid = rsp_valid;
    assign io.rsp_rdata = rsp_rdata;
    assign io.rsp_err   = rsp_err;
    assign io.bus_req   = bus_req;
    assign io.bus_we    = bus_we;
    assign io.bus_addr  = bus_addr;
    assign io.bus_be    = bus_be;
    assign io.bus_wdata = bus_wdata;

    // Decode of the incoming request; illegal size counts as misaligned.
    always_comb begin
        misaligned  = 1'b0;
        be          = 4'b0000;
        wdata_lanes = io.req_wdata;
        case (io.req_size)
            2'b00: begin
                be          = 4'b0001 << io.req_addr[1:0];
                wdata_lanes = {4{io.req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned  = io.req_addr[0];
                be          = io.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{io.req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned  = |io.req_addr[1:0];
                be          = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        sel_byte  = io.bus_rdata[{lane_q, 3'b000} +: 8];
        sel_half  = lane_q[1] ? io.bus_rdata[31:16] : io.bus_rdata[15:0];
        load_data = io.bus_rdata;
        case (size_q)
            2'b00:   load_data = {{24{sext_q & sel_byte[7]}}, sel_byte};
            2'b01:   load_data = {{16{sext_q & sel_half[15]}}, sel_half};
            default: load_data = io.bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 8'd0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            lane_q    <= 2'b00;
            sext_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    count <= 8'd0;
                    if (io.req_valid) begin
                        we_q   <= io.req_we;
                        size_q <= io.req_size;
                        lane_q <= io.req_addr[1:0];
                        sext_q <= io.req_sext;
                        if (misaligned) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state     <= BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= io.req_we;
                            bus_addr  <= {io.req_addr[31:2], 2'b00};
                            bus_be    <= be;
                            bus_wdata <= io.req_we ? wdata_lanes : 32'd0;
                        end
                    end
                end
                // Ack wins over a timeout landing in the same cycle.
                BUS: begin
                    count <= count + 8'd1;
                    if (io.bus_ack) begin
                        state     <= RESP;
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= we_q ? 32'd0 : load_data;
                    end else if (count == LAST_COUNT) begin
                        state     <= RESP;
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'd0;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    count     <= 8'd0;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_align.sv
// Directed bench for mem_access_align built with TIMEOUT=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_access_align;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    mem_access_align_if io();

    mem_access_align #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata);
        io.req_valid = 1'b1;
        io.req_we    = we;
        io.req_size  = size;
        io.req_sext  = sext;
        io.req_addr  = addr;
        io.req_wdata = wdata;
        @(posedge clk); #1;
        io.req_valid = 1'b0;
    endtask

    task automatic ack_cycle(input logic [31:0] rdata);
        io.bus_ack   = 1'b1;
        io.bus_rdata = rdata;
        @(posedge clk); #1;
        io.bus_ack   = 1'b0;
        io.bus_rdata = 32'd0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        total++; if (io.req_ready !== 1'b1) $display("[TB] FAIL rst_ready: got %b expected 1", io.req_ready); else passed++;
        total++; if (io.bus_req !== 1'b0) $display("[TB] FAIL rst_bus_req: got %b expected 0", io.bus_req); else passed++;
        total++; if (io.rsp_valid !== 1'b0) $display("[TB] FAIL rst_rsp_valid: got %b expected 0", io.rsp_valid); else passed++;
        total++; if (io.bus_be !== 4'b0000) $display("[TB] FAIL rst_bus_be: got %b expected 0000", io.bus_be); else passed++;
        total++; if (io.rsp_rdata !== 32'd0) $display("[TB] FAIL rst_rsp_rdata: got %h expected 0", io.rsp_rdata); else passed++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_load_byte_sext;
        send(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'd0);
        total++; if (io.bus_req !== 1'b1) $display("[TB] FAIL lb_bus_req: got %b expected 1", io.bus_req); else passed++;
        total++; if (io.bus_be !== 4'b1000) $display("[TB] FAIL lb_bus_be: got %b expected 1000", io.bus_be); else passed++;
        total++; if (io.bus_addr !== 32'h0000_1000) $display("[TB] FAIL lb_bus_addr: got %h expected 00001000", io.bus_addr); else passed++;
        total++; if (io.bus_we !== 1'b0) $display("[TB] FAIL lb_bus_we: got %b expected 0", io.bus_we); else passed++;
        total++; if (io.bus_wdata !== 32'd0) $display("[TB] FAIL lb_bus_wdata: got %h expected 0", io.bus_wdata); else passed++;
        total++; if (io.req_ready !== 1'b0) $display("[TB] FAIL lb_ready_busy: got %b expected 0", io.req_ready); else passed++;
        ack_cycle(32'h80FF_1234);
        total++; if (io.rsp_valid !== 1'b1) $display("[TB] FAIL lb_rsp_valid: got %b expected 1", io.rsp_valid); else passed++;
        total++; if (io.rsp_rdata !== 32'hFFFF_FF80) $display("[TB] FAIL lb_rsp_rdata: got %h expected ffffff80", io.rsp_rdata); else passed++;
        total++; if (io.rsp_err !== 1'b0) $display("[TB] FAIL lb_rsp_err: got %b expected 0", io.rsp_err); else passed++;
        total++; if (io.bus_req !== 1'b0) $display("[TB] FAIL lb_bus_req_drop: got %b expected 0", io.bus_req); else passed++;
        @(posedge clk); #1;
        total++; if (io.rsp_valid !== 1'b0) $display("[TB] FAIL lb_rsp_pulse: got %b expected 0", io.rsp_valid); else passed++;
        total++; if (io.rsp_rdata !== 32'hFFFF_FF80) $display("[TB] FAIL lb_rdata_hold: got %h expected ffffff80", io.rsp_rdata); else passed++;
    endtask

    task automatic test_load_half_zext;
        send(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'd0);
        total++; if (io.bus_be !== 4'b1100) $display("[TB] FAIL lh_bus_be: got %b expected 1100", io.bus_be); else passed++;
        ack_cycle(32'hBEEF_0001);
        total++; if (io.rsp_rdata !== 32'h0000_BEEF) $display("[TB] FAIL lh_rsp_rdata: got %h expected 0000beef", io.rsp_rdata); else passed++;
        @(posedge clk); #1;
        send(1'b0, 2'b01, 1'b1, 32'h0000_2000, 32'd0);
        total++; if (io.bus_be !== 4'b0011) $display("[TB] FAIL lhs_bus_be: got %b expected 0011", io.bus_be); else passed++;
        ack_cycle(32'h0001_9ABC);
        total++; if (io.rsp_rdata !== 32'hFFFF_9ABC) $display("[TB] FAIL lhs_rsp_rdata: got %h expected ffff9abc", io.rsp_rdata); else passed++;
        @(posedge clk); #1;
        send(1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'd0);
        ack_cycle(32'h0000_9A00);
        total++; if (io.rsp_rdata !== 32'h0000_009A) $display("[TB] FAIL lbu_rsp_rdata: got %h expected 0000009a", io.rsp_rdata); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_store_lanes;
        send(1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'h1234_ABCD);
        total++; if (io.bus_we !== 1'b1) $display("[TB] FAIL sh_bus_we: got %b expected 1", io.bus_we); else passed++;
        total++; if (io.bus_be !== 4'b0011) $display("[TB] FAIL sh_bus_be: got %b expected 0011", io.bus_be); else passed++;
        total++; if (io.bus_wdata !== 32'hABCD_ABCD) $display("[TB] FAIL sh_bus_wdata: got %h expected abcdabcd", io.bus_wdata); else passed++;
        ack_cycle(32'hFFFF_FFFF);
        total++; if (io.rsp_rdata !== 32'd0) $display("[TB] FAIL sh_rsp_rdata: got %h expected 0", io.rsp_rdata); else passed++;
        total++; if (io.rsp_err !== 1'b0) $display("[TB] FAIL sh_rsp_err: got %b expected 0", io.rsp_err); else passed++;
        @(posedge clk); #1;
        send(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_005A);
        total++; if (io.bus_be !== 4'b0010) $display("[TB] FAIL sb_bus_be: got %b expected 0010", io.bus_be); else passed++;
        total++; if (io.bus_wdata !== 32'h5A5A_5A5A) $display("[TB] FAIL sb_bus_wdata: got %h expected 5a5a5a5a", io.bus_wdata); else passed++;
        total++; if (io.bus_addr !== 32'h0000_0010) $display("[TB] FAIL sb_bus_addr: got %h expected 00000010", io.bus_addr); else passed++;
        ack_cycle(32'd0);
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned;
        send(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'd0);
        total++; if (io.bus_req !== 1'b0) $display("[TB] FAIL mis_bus_req: got %b expected 0", io.bus_req); else passed++;
        total++; if (io.rsp_valid !== 1'b1) $display("[TB] FAIL mis_rsp_valid: got %b expected 1", io.rsp_valid); else passed++;
        total++; if (io.rsp_err !== 1'b1) $display("[TB] FAIL mis_rsp_err: got %b expected 1", io.rsp_err); else passed++;
        total++; if (io.rsp_rdata !== 32'd0) $display("[TB] FAIL mis_rsp_rdata: got %h expected 0", io.rsp_rdata); else passed++;
        @(posedge clk); #1;
        total++; if (io.rsp_valid !== 1'b0) $display("[TB] FAIL mis_rsp_pulse: got %b expected 0", io.rsp_valid); else passed++;
        send(1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'd0);
        total++; if (io.bus_req !== 1'b0) $display("[TB] FAIL ill_bus_req: got %b expected 0", io.bus_req); else passed++;
        total++; if (io.rsp_err !== 1'b1) $display("[TB] FAIL ill_rsp_err: got %b expected 1", io.rsp_err); else passed++;
        @(posedge clk); #1;
        send(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'd0);
        total++; if (io.rsp_err !== 1'b1) $display("[TB] FAIL mish_rsp_err: got %b expected 1", io.rsp_err); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        int n;
        n = 0;
        send(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (io.bus_req !== 1'b1) break;
            n++;
            @(posedge clk); #1;
        end
        total++; if (n !== 4) $display("[TB] FAIL to_req_cycles: got %0d expected 4", n); else passed++;
        total++; if (io.rsp_valid !== 1'b1) $display("[TB] FAIL to_rsp_valid: got %b expected 1", io.rsp_valid); else passed++;
        total++; if (io.rsp_err !== 1'b1) $display("[TB] FAIL to_rsp_err: got %b expected 1", io.rsp_err); else passed++;
        total++; if (io.rsp_rdata !== 32'd0) $display("[TB] FAIL to_rsp_rdata: got %h expected 0", io.rsp_rdata); else passed++;
        @(posedge clk); #1;
        send(1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        total++; if (io.bus_req !== 1'b1) $display("[TB] FAIL to4_bus_req: got %b expected 1", io.bus_req); else passed++;
        ack_cycle(32'h1234_5678);
        total++; if (io.rsp_valid !== 1'b1) $display("[TB] FAIL to4_rsp_valid: got %b expected 1", io.rsp_valid); else passed++;
        total++; if (io.rsp_err !== 1'b0) $display("[TB] FAIL to4_rsp_err: got %b expected 0", io.rsp_err); else passed++;
        total++; if (io.rsp_rdata !== 32'h1234_5678) $display("[TB] FAIL to4_rsp_rdata: got %h expected 12345678", io.rsp_rdata); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_bus;
        int pulses;
        pulses = 0;
        send(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'd0);
        total++; if (io.bus_req !== 1'b1) $display("[TB] FAIL rmb_bus_req: got %b expected 1", io.bus_req); else passed++;
        rst = 1'b1;
        #1;
        total++; if (io.bus_req !== 1'b0) $display("[TB] FAIL rmb_bus_req_drop: got %b expected 0", io.bus_req); else passed++;
        total++; if (io.req_ready !== 1'b1) $display("[TB] FAIL rmb_ready: got %b expected 1", io.req_ready); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        io.bus_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (io.rsp_valid === 1'b1) pulses++;
        end
        io.bus_ack = 1'b0;
        total++; if (pulses !== 0) $display("[TB] FAIL rmb_no_rsp: got %0d expected 0", pulses); else passed++;
    endtask

    task automatic test_back_to_back;
        io.req_valid = 1'b1;
        io.req_we    = 1'b0;
        io.req_size  = 2'b10;
        io.req_sext  = 1'b0;
        io.req_addr  = 32'h0000_0100;
        io.bus_ack   = 1'b1;
        io.bus_rdata = 32'hCAFE_F00D;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            total++; if (io.req_ready !== (k % 3 == 0)) $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", k, io.req_ready, (k % 3 == 0)); else passed++;
            total++; if (io.rsp_valid !== (k % 3 == 2)) $display("[TB] FAIL b2b_rsp_valid[%0d]: got %b expected %b", k, io.rsp_valid, (k % 3 == 2)); else passed++;
            if (k % 3 == 2) begin
                total++; if (io.rsp_rdata !== 32'hCAFE_F00D) $display("[TB] FAIL b2b_rdata[%0d]: got %h expected cafef00d", k, io.rsp_rdata); else passed++;
            end
        end
        io.req_valid = 1'b0;
        io.bus_ack   = 1'b0;
        io.bus_rdata = 32'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        io.req_valid = 1'b0;
        io.req_we    = 1'b0;
        io.req_size  = 2'b00;
        io.req_sext  = 1'b0;
        io.req_addr  = 32'd0;
        io.req_wdata = 32'd0;
        io.bus_ack   = 1'b0;
        io.bus_rdata = 32'd0;
        test_reset;
        @(posedge clk); #1;
        test_load_byte_sext;
        test_load_half_zext;
        test_store_lanes;
        test_misaligned;
        test_timeout;
        test_reset_mid_bus;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
